// File: rtl/prog_mem_loadable.sv
// Writable program memory: byte-stream loader (valid/ready) plus a registered one-cycle fetch port.
// Optional per-word even-parity storage and checking is enabled by defining PROG_MEM_PARITY_EN.
module prog_mem_loadable #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              load_busy,
    output logic              load_done,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] code_address,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              parity_err
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned BCW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW     = ADDR_W + 1;

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     wr_addr_q, wr_addr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [LW-1:0]     len_eff;
    logic [DATA_W-1:0] asm_shift;
    logic              mem_we;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic              in_range;
    logic              fetch_go;
    logic [DATA_W-1:0] rd_word;
    logic              rd_perr;

    assign len_eff   = (load_len > LW'(DEPTH)) ? LW'(DEPTH) : load_len;
    // MSB-first assembly: each accepted byte shifts in at the bottom.
    assign asm_shift = (asm_q << 8) | DATA_W'(ld_data);
    assign wr_idx    = wr_addr_q[MEM_AW-1:0];
    assign rd_idx    = code_address[MEM_AW-1:0];
    assign in_range  = {1'b0, code_address} < LW'(DEPTH);
    assign fetch_go  = (state_q == StIdle) && fetch_en;
    assign rd_word   = in_range ? mem[rd_idx] : '0;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = StLoad;
                        len_d      = len_eff;
                        wr_addr_d  = '0;
                        byte_cnt_d = '0;
                        asm_d      = '0;
                    end
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    if (byte_cnt_q == BCW'(BYTES - 1)) begin
                        mem_we     = 1'b1;
                        byte_cnt_d = '0;
                        asm_d      = '0;
                        wr_addr_d  = wr_addr_q + LW'(1);
                        if (wr_addr_q == len_q - LW'(1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        asm_d      = asm_shift;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Fetches are only served in IDLE; during LOAD the last instruction is held.
    always_comb begin
        instr_d = instr_q;
        valid_d = fetch_go;
        perr_d  = 1'b0;
        if (fetch_go) begin
            instr_d = rd_word;
            perr_d  = rd_perr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_addr_q  <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            done_q     <= 1'b0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            done_q     <= done_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
        end
    end

    // Array is never cleared; a reset edge blocks the write but keeps earlier words.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[wr_idx] <= asm_shift;
        end
    end

`ifdef PROG_MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            par_mem[wr_idx] <= ^asm_shift;
        end
    end

    assign rd_perr = in_range && (par_mem[rd_idx] != (^rd_word));
`else
    assign rd_perr = 1'b0;
`endif

    assign ld_ready    = (state_q == StLoad);
    assign load_busy   = (state_q == StLoad);
    assign load_done   = done_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign parity_err  = perr_q;

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Directed bench for prog_mem_loadable: loads, fetches via a scoreboard queue, boundaries, reset.
// Define PROG_MEM_PARITY_EN for both files to include the parity-flip step.
module tb_prog_mem_loadable;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 40;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        ld_data;
    logic              ld_valid;
    logic              ld_ready;
    logic              load_busy;
    logic              load_done;
    logic              fetch_en;
    logic [ADDR_W-1:0] code_address;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              parity_err;

    prog_mem_loadable #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_len    (load_len),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .fetch_en    (fetch_en),
        .code_address(code_address),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model [DEPTH];
    logic        bad_par [DEPTH];
    logic [15:0] wbuf [64];
    logic [16:0] sb_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit last,
                             input bit chk_hold, input logic [15:0] held);
        bit sent = 1'b0;
        int tries = 0;
        while (!sent) begin
            check("ld_ready", ld_ready, 1);
            ld_valid = gaps ? ((tries % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
            ld_data  = b;
            sent     = ld_valid;
            cycle();
            tries++;
            if (chk_hold) begin
                check("valid_in_load", instr_valid, 0);
                check("instr_hold", instruction, held);
            end
            check("load_done_timing", load_done, (last && sent) ? 1 : 0);
        end
        ld_valid = 1'b0;
    endtask

    task automatic do_load(input int len, input int nwords, input bit gaps, input bit fetch_during);
        logic [15:0] held = '0;
        load_len   = (ADDR_W + 1)'(len);
        load_start = 1'b1;
        if (fetch_during) begin
            fetch_en     = 1'b1;
            code_address = 4;
        end
        cycle();
        load_start = 1'b0;
        check("busy_after_start", load_busy, 1);
        if (fetch_during) begin
            // Same-edge fetch is served with the old contents.
            check("same_edge_valid", instr_valid, 1);
            check("same_edge_data", instruction, model[4]);
            held = model[4];
        end
        for (int w = 0; w < nwords; w++) begin
            send_byte(wbuf[w][15:8], gaps, 1'b0, fetch_during, held);
            send_byte(wbuf[w][7:0], gaps, w == nwords - 1, fetch_during, held);
            model[w] = wbuf[w];
        end
        fetch_en = 1'b0;
        check("busy_after_load", load_busy, 0);
        check("ready_after_load", ld_ready, 0);
        cycle();
        check("done_one_cycle", load_done, 0);
    endtask

    task automatic fetch_one(input int addr);
        logic [16:0] exp;
        logic [16:0] obs;
        fetch_en     = 1'b1;
        code_address = ADDR_W'(addr);
        if (addr < DEPTH) sb_q.push_back({bad_par[addr], model[addr]});
        else              sb_q.push_back(17'h0);
        cycle();
        check("fetch_valid", instr_valid, 1);
        exp = sb_q.pop_front();
        obs = {parity_err, instruction};
        check("fetch_word", obs, exp);
    endtask

    task automatic fetch_stop();
        fetch_en = 1'b0;
        cycle();
        check("valid_drop", instr_valid, 0);
        check("perr_idle", parity_err, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) bad_par[i] = 1'b0;
        rst_n        = 1'b0;
        load_start   = 1'b0;
        load_len     = '0;
        ld_data      = '0;
        ld_valid     = 1'b0;
        fetch_en     = 1'b0;
        code_address = '0;

        // Reset
        cycle();
        cycle();
        check("rst_ready", ld_ready, 0);
        check("rst_busy", load_busy, 0);
        check("rst_done", load_done, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instruction, 0);
        check("rst_perr", parity_err, 0);
        rst_n = 1'b1;
        cycle();
        check("idle_valid", instr_valid, 0);

        // Five-word gap-free load, then back-to-back fetches
        wbuf[0] = 16'hD205; wbuf[1] = 16'h1203; wbuf[2] = 16'hC200;
        wbuf[3] = 16'h0000; wbuf[4] = 16'hA003;
        do_load(5, 5, 1'b0, 1'b0);
        for (int a = 0; a < 5; a++) fetch_one(a);
        fetch_stop();

        // Three-word load with ld_valid gaps, fetch held high throughout
        wbuf[0] = 16'hBEEF; wbuf[1] = 16'h0102; wbuf[2] = 16'hF00D;
        do_load(3, 3, 1'b1, 1'b1);
        for (int a = 0; a < 5; a++) fetch_one(a);
        fetch_stop();

        // load_len = 0: done pulse next cycle, no writes
        load_len   = '0;
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        check("len0_done", load_done, 1);
        check("len0_busy", load_busy, 0);
        cycle();
        check("len0_done_drop", load_done, 0);
        fetch_one(0);
        fetch_one(2);

        // Out-of-range fetches
        fetch_one(DEPTH);
        fetch_one(63);
        fetch_stop();

        // Clamped load: DEPTH+3 requested, DEPTH words written
        for (int w = 0; w < DEPTH; w++) wbuf[w] = 16'(w * 16'h0101) ^ 16'h5A3C;
        do_load(DEPTH + 3, DEPTH, 1'b0, 1'b0);
        fetch_one(0);
        fetch_one(17);
        fetch_one(DEPTH - 1);
        fetch_one(DEPTH);
        fetch_stop();

        // Reset after byte 3 of a four-word load
        load_len   = 4;
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        send_byte(8'h11, 1'b0, 1'b0, 1'b0, '0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0, '0);
        send_byte(8'h33, 1'b0, 1'b0, 1'b0, '0);
        model[0] = 16'h1122;
        rst_n = 1'b0;
        cycle();
        check("mid_rst_busy", load_busy, 0);
        check("mid_rst_ready", ld_ready, 0);
        check("mid_rst_done", load_done, 0);
        rst_n = 1'b1;
        cycle();
        check("post_rst_done", load_done, 0);
        check("post_rst_busy", load_busy, 0);
        fetch_one(0);
        fetch_one(1);
        fetch_stop();
        // A fresh load must not see the discarded partial byte
        wbuf[0] = 16'h7788;
        do_load(1, 1, 1'b0, 1'b0);
        fetch_one(0);
        fetch_one(1);
        fetch_stop();

`ifdef PROG_MEM_PARITY_EN
        dut.mem[1] = dut.mem[1] ^ 16'h0010;
        model[1]   = model[1] ^ 16'h0010;
        bad_par[1] = 1'b1;
        fetch_one(0);
        fetch_one(1);
        fetch_one(2);
        fetch_stop();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
